// File: rtl/inv_mixcolumns_addkey_serial_if.sv
// inv_mixcolumns_addkey_serial_if: input/output handshake bundle for the inverse mix+key layer
interface inv_mixcolumns_addkey_serial_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    modport master (
        output in_valid, in_state, in_key, out_ready,
        input  in_ready, out_valid, out_state
    );
    modport slave (
        input  in_valid, in_state, in_key, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/inv_mixcolumns_addkey_serial.sv
// inv_mixcolumns_addkey_serial: strips the round key, then applies the involutory column mix a few columns per cycle
module inv_mixcolumns_addkey_serial #(
    parameter int COLS_PER_CYCLE = 2
) (
    input logic                           clk,
    input logic                           rst,
    inv_mixcolumns_addkey_serial_if.slave bus
);
    localparam int N_STEPS = 8 / COLS_PER_CYCLE;
    localparam int SW = N_STEPS > 1 ? $clog2(N_STEPS) : 1;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4 && COLS_PER_CYCLE != 8) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_d;
    logic [SW-1:0]   step;
    logic [127:0]    work, result, mixed, sel;

    // each output nibble is the XOR of the other three nibbles in its column
    always_comb begin
        mixed = '0;
        sel = '0;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 4; r++) begin
                mixed[4*(8*r+c) +: 4] = work[4*c +: 4] ^ work[4*(8+c) +: 4] ^ work[4*(16+c) +: 4]
                                      ^ work[4*(24+c) +: 4] ^ work[4*(8*r+c) +: 4];
                sel[4*(8*r+c) +: 4] = {4{c / COLS_PER_CYCLE == int'(step)}};
            end
        end
    end

    always_comb begin
        state_d = state;
        if (state == IDLE && bus.in_valid) state_d = BUSY;
        if (state == BUSY && step == SW'(N_STEPS - 1)) state_d = DONE;
        if (state == DONE && bus.out_ready) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            step   <= '0;
            work   <= '0;
            result <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && bus.in_valid) begin
                work   <= bus.in_state ^ bus.in_key;
                result <= '0;
                step   <= '0;
            end else if (state == BUSY) begin
                result <= (result & ~sel) | (mixed & sel);
                step   <= step + 1'b1;
            end
        end
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.out_state = result;
endmodule
